// File: rtl/ps2_scan_rx_pkg.sv
// Shared scan-code constants, receiver state type and frame parity helper
// for the PS/2 keyboard receive path.
`timescale 1ns/1ps
package ps2_scan_rx_pkg;

  localparam logic [7:0] P_SCAN_ENTER     = 8'h5A;
  localparam logic [7:0] P_SCAN_BACKSPACE = 8'h66;
  localparam logic [7:0] P_SCAN_BREAK     = 8'hF0;
  localparam logic [7:0] P_SCAN_EXT       = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan_rx_line_filter.sv
// Two-flop synchroniser followed by a level debouncer: the output follows
// the synced input only after LEN consecutive differing samples.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int unsigned LEN  = 8,
  parameter logic        INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CW = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {2{INIT}};
      cnt  <= '0;
      filt <= INIT;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks parity/stop,
// strips break/extended prefixes and presents held make codes with a strobe.
`timescale 1ns/1ps
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] SCAN_CODE,
  output logic       SCAN_EXT,
  output logic       SCAN_READY,
  output logic       FRAME_ERR
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic ps2_clk_f;
  logic ps2_data_f;
  logic clk_prev;
  logic sample;

  ps2_line_filter #(.LEN(FILTER_LEN), .INIT(1'b1)) u_clk_filt (
    .clk   (CLK),
    .reset (RESET),
    .raw   (PS2_CLK),
    .filt  (ps2_clk_f)
  );

  ps2_line_filter #(.LEN(1), .INIT(1'b1)) u_data_filt (
    .clk   (CLK),
    .reset (RESET),
    .raw   (PS2_DATA),
    .filt  (ps2_data_f)
  );

  assign sample = clk_prev & ~ps2_clk_f;

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          brk, brk_n;
  logic          ext, ext_n;
  logic [7:0]    code_n;
  logic          code_ext_n;
  logic          ready_n;
  logic          err_n;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_prev   <= 1'b1;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      brk        <= 1'b0;
      ext        <= 1'b0;
      SCAN_CODE  <= '0;
      SCAN_EXT   <= 1'b0;
      SCAN_READY <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      clk_prev   <= ps2_clk_f;
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      to_cnt     <= to_cnt_n;
      brk        <= brk_n;
      ext        <= ext_n;
      SCAN_CODE  <= code_n;
      SCAN_EXT   <= code_ext_n;
      SCAN_READY <= ready_n;
      FRAME_ERR  <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par;
    to_cnt_n   = to_cnt;
    brk_n      = brk;
    ext_n      = ext;
    code_n     = SCAN_CODE;
    code_ext_n = SCAN_EXT;
    ready_n    = 1'b0;
    err_n      = 1'b0;

    // A falling edge in the same cycle as the timeout limit restarts the count.
    if (state != ST_IDLE && !sample && to_cnt == TO_LAST) begin
      err_n    = 1'b1;
      brk_n    = 1'b0;
      ext_n    = 1'b0;
      to_cnt_n = '0;
      state_n  = ST_IDLE;
    end else begin
      if (state == ST_IDLE || sample) begin
        to_cnt_n = '0;
      end else begin
        to_cnt_n = to_cnt + TW'(1);
      end

      unique case (state)
        ST_IDLE: begin
          if (sample && !ps2_data_f) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
        end
        ST_DATA: begin
          if (sample) begin
            shreg_n   = {ps2_data_f, shreg[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (sample) begin
            par_n   = ps2_data_f;
            state_n = ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            state_n = ST_IDLE;
            if (ps2_data_f && frame_parity_ok(shreg, par)) begin
              if (shreg == P_SCAN_BREAK) begin
                brk_n = 1'b1;
              end else if (shreg == P_SCAN_EXT) begin
                ext_n = 1'b1;
              end else if (brk) begin
                brk_n = 1'b0;
                ext_n = 1'b0;
              end else begin
                code_n     = shreg;
                code_ext_n = ext;
                ready_n    = 1'b1;
                ext_n      = 1'b0;
              end
            end else begin
              err_n = 1'b1;
              brk_n = 1'b0;
              ext_n = 1'b0;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: table-driven frames with a strobe scoreboard, plus
// timeout, glitch and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_ps2_scan_rx;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] scan_code;
  logic       scan_ext;
  logic       scan_ready;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .PS2_CLK    (ps2c),
    .PS2_DATA   (ps2d),
    .SCAN_CODE  (scan_code),
    .SCAN_EXT   (scan_ext),
    .SCAN_READY (scan_ready),
    .FRAME_ERR  (frame_err)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic       ext;
  } exp_t;

  // kind: 0 = no strobe, 1 = SCAN_READY, 2 = FRAME_ERR
  typedef struct {
    logic [7:0] code;
    bit         flip;
    bit         stop;
    int         kind;
    logic [7:0] exp_code;
    logic       exp_ext;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (scan_ready || frame_err)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: ready=%0b err=%0b want none", scan_ready, frame_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", 16'({scan_ready, frame_err}), e.is_err ? 16'h1 : 16'h2);
        check("strobe_code", 16'(scan_code), 16'(e.code));
        check("strobe_ext", 16'(scan_ext), 16'(e.ext));
      end
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit flip, input bit stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^code) ^ flip, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      cyc(HALF);
      ps2c = 1'b0;
      cyc(HALF);
      ps2c = 1'b1;
    end
    cyc(HALF);
    ps2d = 1'b1;
  endtask

  task automatic push(input logic is_err, input logic [7:0] code, input logic ext);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.ext    = ext;
    sb.push_back(e);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_strobe: pending=%0d want 0", sb.size());
      sb.delete();
    end
    cyc(10);
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{8'h5A, 1'b0, 1'b1, 1, 8'h5A, 1'b0};
    vecs[1]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b1, 0, 8'h1C, 1'b0};
    vecs[3]  = '{8'h1C, 1'b0, 1'b1, 0, 8'h1C, 1'b0};
    vecs[4]  = '{8'hE0, 1'b0, 1'b1, 0, 8'h1C, 1'b0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b1};
    vecs[6]  = '{8'h66, 1'b0, 1'b1, 1, 8'h66, 1'b0};
    vecs[7]  = '{8'h66, 1'b1, 1'b1, 2, 8'h66, 1'b0};
    vecs[8]  = '{8'h66, 1'b0, 1'b1, 1, 8'h66, 1'b0};
    vecs[9]  = '{8'h29, 1'b0, 1'b0, 2, 8'h66, 1'b0};
    vecs[10] = '{8'hE0, 1'b0, 1'b1, 0, 8'h66, 1'b0};
    vecs[11] = '{8'hF0, 1'b0, 1'b1, 0, 8'h66, 1'b0};
    vecs[12] = '{8'h75, 1'b0, 1'b1, 0, 8'h66, 1'b0};
    vecs[13] = '{8'h5A, 1'b0, 1'b1, 1, 8'h5A, 1'b0};
    vecs[14] = '{8'hE0, 1'b0, 1'b1, 0, 8'h5A, 1'b0};
    vecs[15] = '{8'h1C, 1'b1, 1'b1, 2, 8'h5A, 1'b0};
    vecs[16] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0};

    rst = 1'b1;
    cyc(5);
    check("rst_code", 16'(scan_code), 16'h00);
    check("rst_ext", 16'(scan_ext), 16'h0);
    check("rst_ready", 16'(scan_ready), 16'h0);
    check("rst_err", 16'(frame_err), 16'h0);
    rst = 1'b0;
    cyc(20);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].kind != 0)
        push(vecs[i].kind == 2, vecs[i].exp_code, vecs[i].exp_ext);
      send_frame(vecs[i].code, vecs[i].flip, vecs[i].stop, 11);
      drain(60);
      check($sformatf("hold_code[%0d]", i), 16'(scan_code), 16'(vecs[i].exp_code));
      check($sformatf("hold_ext[%0d]", i), 16'(scan_ext), 16'(vecs[i].exp_ext));
    end

    // Truncated frame: start plus five data bits, then the clock stops.
    push(1'b1, 8'h1C, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 6);
    drain(TO + 200);
    push(1'b0, 8'h29, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 11);
    drain(60);
    check("after_timeout_code", 16'(scan_code), 16'h29);

    // Clock glitch one sample short of the filter length, data low as if a start bit.
    ps2d = 1'b0;
    ps2c = 1'b0;
    cyc(FL - 1);
    ps2c = 1'b1;
    ps2d = 1'b1;
    cyc(60);
    push(1'b0, 8'h5A, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    drain(60);
    check("after_glitch_code", 16'(scan_code), 16'h5A);

    // Reset in the middle of a frame.
    send_frame(8'h66, 1'b0, 1'b1, 4);
    rst = 1'b1;
    cyc(3);
    check("midrst_code", 16'(scan_code), 16'h00);
    check("midrst_ext", 16'(scan_ext), 16'h0);
    check("midrst_ready", 16'(scan_ready), 16'h0);
    check("midrst_err", 16'(frame_err), 16'h0);
    rst = 1'b0;
    cyc(50);
    check("post_rst_pending", 16'(sb.size()), 16'h0);
    push(1'b0, 8'h66, 1'b0);
    send_frame(8'h66, 1'b0, 1'b1, 11);
    drain(60);
    check("post_rst_code", 16'(scan_code), 16'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
